// File: rtl/serie_paralelo_rx_pkg.sv
// -----------------------------------------------------------------------------
// serie_paralelo_rx_pkg
// Shared definitions for the serial-to-parallel receiver:
//   - default COMMA symbol (idle / alignment marker, never valid payload)
//   - default number of aligned commas required before the link is declared up
//   - receiver state encoding (2'd3 is unreachable and decodes as HUNT)
// -----------------------------------------------------------------------------
package serie_paralelo_rx_pkg;

  localparam logic [7:0] COMMA_DEFAULT       = 8'hBC;
  localparam int         COMMA_COUNT_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,  // sliding search for COMMA on every bit
    ST_ALIGN  = 2'd1,  // boundary found, counting consecutive aligned commas
    ST_ACTIVE = 2'd2   // link up, payload bytes presented with valid strobe
  } state_e;

endpackage : serie_paralelo_rx_pkg

// File: rtl/serie_paralelo_rx_sp_shift8.sv
// -----------------------------------------------------------------------------
// serie_paralelo_rx_sp_shift8
// 8-bit serial-in shift register, MSB first: every clock the register moves
// one place towards the MSB and the new bit enters at bit 0.
// Ports:
//   clk_i     in   1  bit clock
//   rst_n_i   in   1  asynchronous clear, active-low
//   data_i    in   1  serial bit
//   shreg_o   out  8  current register contents
// -----------------------------------------------------------------------------
module serie_paralelo_rx_sp_shift8 (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       data_i,
  output logic [7:0] shreg_o
);

  logic [7:0] shreg_q;
  logic [7:0] shreg_d;

  assign shreg_d = {shreg_q[6:0], data_i};

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, as real flops do.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign shreg_o = shreg_q;

endmodule : serie_paralelo_rx_sp_shift8

// File: rtl/serie_paralelo_rx.sv
// -----------------------------------------------------------------------------
// serie_paralelo_rx
// Receiver side of the parallel-to-serial link. Rebuilds bytes from a serial
// MSB-first stream (one bit per clk_32f). The upstream stage sends COMMA while
// idle; the block slides over the stream looking for COMMA, then requires
// COMMA_COUNT consecutive boundary-aligned commas before declaring the link
// active. Once active, every non-COMMA byte is presented with valid_out.
// Ports:
//   clk_32f    in   1  bit clock, all logic on posedge
//   reset      in   1  asynchronous reset, active-low
//   data_in    in   1  serial data, MSB first
//   data_out   out  8  last completed byte (updated on each aligned boundary)
//   valid_out  out  1  data_out is a payload byte (ACTIVE and byte != COMMA)
//   byte_tick  out  1  one-cycle pulse on each aligned byte boundary
//   active     out  1  link aligned; held until reset
// Outputs are registered: they change on the edge that samples a byte's last
// bit, one cycle after that bit was presented, with no gaps between bytes.
// -----------------------------------------------------------------------------
module serie_paralelo_rx
  import serie_paralelo_rx_pkg::*;
#(
  parameter logic [7:0] COMMA       = COMMA_DEFAULT,
  parameter int         COMMA_COUNT = COMMA_COUNT_DEFAULT
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_tick,
  output logic       active
);

  localparam int CW = $clog2(COMMA_COUNT + 1);

  // ---------------------------------------------------------------------------
  // Shift register and byte window
  // ---------------------------------------------------------------------------
  logic [7:0] shreg;
  logic [7:0] window;
  logic       unused_shreg_msb;

  serie_paralelo_rx_sp_shift8 u_shift8 (
    .clk_i   (clk_32f),
    .rst_n_i (reset),
    .data_i  (data_in),
    .shreg_o (shreg)
  );

  // The window already includes the bit being sampled on this edge, so a
  // byte is recognised on the same edge that shifts its last bit in.
  assign window           = {shreg[6:0], data_in};
  assign unused_shreg_msb = shreg[7];

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_e        state_q,     state_d;
  logic [2:0]    bit_cnt_q,   bit_cnt_d;
  logic [CW-1:0] comma_cnt_q, comma_cnt_d;
  logic [7:0]    data_out_q,  data_out_d;
  logic          valid_q,     valid_d;
  logic          tick_q,      tick_d;
  logic          active_q,    active_d;

  // ---------------------------------------------------------------------------
  // Shared decode
  // ---------------------------------------------------------------------------
  logic          is_comma;
  logic          boundary;
  logic [CW-1:0] comma_inc;
  logic          comma_done;

  assign is_comma   = (window == COMMA);
  // bit_cnt only runs once a boundary has been established.
  assign boundary   = ((state_q == ST_ALIGN) || (state_q == ST_ACTIVE)) &&
                      (bit_cnt_q == 3'd7);
  assign comma_inc  = comma_cnt_q + CW'(1);
  assign comma_done = (comma_inc == CW'(COMMA_COUNT));

  // ---------------------------------------------------------------------------
  // Process 1: state and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_HUNT;
      bit_cnt_q   <= '0;
      comma_cnt_q <= '0;
      data_out_q  <= '0;
      valid_q     <= 1'b0;
      tick_q      <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      data_out_q  <= data_out_d;
      valid_q     <= valid_d;
      tick_q      <= tick_d;
      active_q    <= active_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Process 2: next state, bit counter, comma counter
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q + 3'd1;   // wraps 7 -> 0, bytes are back-to-back
    comma_cnt_d = comma_cnt_q;

    case (state_q)
      ST_ALIGN: begin
        if (boundary) begin
          if (is_comma) begin
            comma_cnt_d = comma_inc;
            if (comma_done) begin
              state_d = ST_ACTIVE;
            end
          end else begin
            // A non-comma while aligning means the boundary was a false lock.
            state_d     = ST_HUNT;
            comma_cnt_d = '0;
          end
        end
      end

      ST_ACTIVE: begin
        // No re-alignment once active; only reset leaves this state.
        state_d = ST_ACTIVE;
      end

      default: begin
        // ST_HUNT, and the unused encoding 2'd3 which behaves as HUNT.
        state_d     = ST_HUNT;
        bit_cnt_d   = '0;
        comma_cnt_d = '0;
        if (is_comma) begin
          // The comma just completed marks the boundary; it counts as the first.
          state_d     = ST_ALIGN;
          comma_cnt_d = CW'(1);
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Process 3: output register next values
  // ---------------------------------------------------------------------------
  always_comb begin
    data_out_d = data_out_q;
    valid_d    = valid_q;
    tick_d     = 1'b0;
    active_d   = active_q;

    case (state_q)
      ST_ALIGN: begin
        valid_d = 1'b0;
        if (boundary) begin
          data_out_d = window;
          tick_d     = 1'b1;
          if (is_comma && comma_done) begin
            active_d = 1'b1;
          end
        end
      end

      ST_ACTIVE: begin
        active_d = 1'b1;
        if (boundary) begin
          data_out_d = window;
          tick_d     = 1'b1;
          // A payload byte equal to COMMA is illegal upstream and reads as idle.
          valid_d    = !is_comma;
        end
      end

      default: begin
        // The HUNT detection edge is not a reported boundary.
        valid_d  = 1'b0;
        active_d = 1'b0;
      end
    endcase
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_q;
  assign byte_tick = tick_q;
  assign active    = active_q;

endmodule : serie_paralelo_rx

// File: tb/tb_serie_paralelo_rx.sv
// -----------------------------------------------------------------------------
// tb_serie_paralelo_rx
// Directed bench for serie_paralelo_rx. data_in is driven on the falling edge;
// outputs are sampled 1 time unit after the rising edge that sampled the bit.
// -----------------------------------------------------------------------------
module tb_serie_paralelo_rx;

  localparam logic [7:0] BC = 8'hBC;

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b0;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_tick;
  logic       active;

  int n_checks = 0;
  int n_fail   = 0;

  // Observations collected by send_byte.
  int         extra_ticks;   // ticks seen on bits other than the last
  logic [7:0] mid_data;      // data_out in the middle of the byte
  logic       mid_valid;     // valid_out in the middle of the byte

  serie_paralelo_rx dut (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .byte_tick (byte_tick),
    .active    (active)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic send_bit(input logic b);
    @(negedge clk_32f);
    data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    extra_ticks = 0;
    for (int i = 7; i >= 0; i--) begin
      send_bit(b[i]);
      if (i > 0 && byte_tick === 1'b1) extra_ticks++;
      if (i == 4) begin
        mid_data  = data_out;
        mid_valid = valid_out;
      end
    end
  endtask

  // T1: reset held with random data, then one cycle after release.
  task automatic test_reset();
    reset = 1'b0;
    repeat (16) begin
      @(negedge clk_32f);
      data_in = 1'($urandom_range(0, 1));
    end
    #1;
    n_checks++; if (data_out  !== 8'h00) begin n_fail++; $display("FAIL reset_data_out got %h exp 00", data_out); end
    n_checks++; if (valid_out !== 1'b0)  begin n_fail++; $display("FAIL reset_valid got %b exp 0", valid_out); end
    n_checks++; if (byte_tick !== 1'b0)  begin n_fail++; $display("FAIL reset_tick got %b exp 0", byte_tick); end
    n_checks++; if (active    !== 1'b0)  begin n_fail++; $display("FAIL reset_active got %b exp 0", active); end
    @(negedge clk_32f);
    reset   = 1'b1;
    data_in = 1'b0;
    @(posedge clk_32f);
    #1;
    n_checks++; if (data_out  !== 8'h00) begin n_fail++; $display("FAIL post_reset_data_out got %h exp 00", data_out); end
    n_checks++; if (valid_out !== 1'b0)  begin n_fail++; $display("FAIL post_reset_valid got %b exp 0", valid_out); end
    n_checks++; if (byte_tick !== 1'b0)  begin n_fail++; $display("FAIL post_reset_tick got %b exp 0", byte_tick); end
    n_checks++; if (active    !== 1'b0)  begin n_fail++; $display("FAIL post_reset_active got %b exp 0", active); end
  endtask

  // T2: junk bits, then four commas.
  task automatic test_acquisition();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_byte(BC);
    n_checks++; if (byte_tick !== 1'b0) begin n_fail++; $display("FAIL acq_hunt_tick got %b exp 0", byte_tick); end
    n_checks++; if (active    !== 1'b0) begin n_fail++; $display("FAIL acq_hunt_active got %b exp 0", active); end
    for (int k = 2; k <= 4; k++) begin
      send_byte(BC);
      n_checks++; if (byte_tick !== 1'b1) begin n_fail++; $display("FAIL acq_tick comma %0d got %b exp 1", k, byte_tick); end
      n_checks++; if (extra_ticks != 0)   begin n_fail++; $display("FAIL acq_extra_ticks comma %0d got %0d exp 0", k, extra_ticks); end
      n_checks++; if (data_out !== BC)    begin n_fail++; $display("FAIL acq_data comma %0d got %h exp bc", k, data_out); end
      n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL acq_valid comma %0d got %b exp 0", k, valid_out); end
      n_checks++; if (active !== (k == 4)) begin n_fail++; $display("FAIL acq_active comma %0d got %b exp %b", k, active, (k == 4)); end
    end
  endtask

  // T3: payload bytes while active, then an idle comma.
  task automatic test_payload();
    logic [7:0] vec [8];
    logic [7:0] prev_data;
    logic       prev_valid;
    vec = '{8'hFF, 8'hDD, 8'hEE, 8'hCC, 8'hBB, 8'h99, 8'hAA, 8'h88};
    prev_data  = BC;
    prev_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      send_byte(vec[k]);
      n_checks++; if (mid_data !== prev_data)   begin n_fail++; $display("FAIL pay_hold_data byte %0d got %h exp %h", k, mid_data, prev_data); end
      n_checks++; if (mid_valid !== prev_valid) begin n_fail++; $display("FAIL pay_hold_valid byte %0d got %b exp %b", k, mid_valid, prev_valid); end
      n_checks++; if (byte_tick !== 1'b1)       begin n_fail++; $display("FAIL pay_tick byte %0d got %b exp 1", k, byte_tick); end
      n_checks++; if (extra_ticks != 0)         begin n_fail++; $display("FAIL pay_extra_ticks byte %0d got %0d exp 0", k, extra_ticks); end
      n_checks++; if (data_out !== vec[k])      begin n_fail++; $display("FAIL pay_data byte %0d got %h exp %h", k, data_out, vec[k]); end
      n_checks++; if (valid_out !== 1'b1)       begin n_fail++; $display("FAIL pay_valid byte %0d got %b exp 1", k, valid_out); end
      prev_data  = vec[k];
      prev_valid = 1'b1;
    end
    send_byte(BC);
    n_checks++; if (data_out  !== BC)   begin n_fail++; $display("FAIL idle_data got %h exp bc", data_out); end
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL idle_valid got %b exp 0", valid_out); end
    n_checks++; if (byte_tick !== 1'b1) begin n_fail++; $display("FAIL idle_tick got %b exp 1", byte_tick); end
    n_checks++; if (active    !== 1'b1) begin n_fail++; $display("FAIL idle_active got %b exp 1", active); end
  endtask

  // T4: two commas then a non-comma drops back to HUNT; four commas re-acquire.
  task automatic test_failed_align();
    @(negedge clk_32f);
    reset = 1'b0;
    @(negedge clk_32f);
    reset   = 1'b1;
    data_in = 1'b0;
    send_byte(BC);
    send_byte(BC);
    send_byte(8'h30);
    n_checks++; if (byte_tick !== 1'b1)  begin n_fail++; $display("FAIL fail_tick got %b exp 1", byte_tick); end
    n_checks++; if (data_out  !== 8'h30) begin n_fail++; $display("FAIL fail_data got %h exp 30", data_out); end
    n_checks++; if (valid_out !== 1'b0)  begin n_fail++; $display("FAIL fail_valid got %b exp 0", valid_out); end
    n_checks++; if (active    !== 1'b0)  begin n_fail++; $display("FAIL fail_active got %b exp 0", active); end
    send_byte(BC);
    // Back in HUNT, so this comma is a detection, not a reported boundary.
    n_checks++; if (byte_tick !== 1'b0)  begin n_fail++; $display("FAIL reacq_hunt_tick got %b exp 0", byte_tick); end
    n_checks++; if (extra_ticks != 0)    begin n_fail++; $display("FAIL reacq_hunt_extra got %0d exp 0", extra_ticks); end
    send_byte(BC);
    send_byte(BC);
    n_checks++; if (active    !== 1'b0)  begin n_fail++; $display("FAIL reacq_active_3 got %b exp 0", active); end
    send_byte(BC);
    n_checks++; if (active    !== 1'b1)  begin n_fail++; $display("FAIL reacq_active_4 got %b exp 1", active); end
    n_checks++; if (byte_tick !== 1'b1)  begin n_fail++; $display("FAIL reacq_tick_4 got %b exp 1", byte_tick); end
  endtask

  // T5: reset three bits into byte 77 while active.
  task automatic test_reset_mid_active();
    int ticks;
    logic [7:0] tail [2];
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if (data_out  !== 8'h00) begin n_fail++; $display("FAIL mid_rst_data got %h exp 00", data_out); end
    n_checks++; if (valid_out !== 1'b0)  begin n_fail++; $display("FAIL mid_rst_valid got %b exp 0", valid_out); end
    n_checks++; if (byte_tick !== 1'b0)  begin n_fail++; $display("FAIL mid_rst_tick got %b exp 0", byte_tick); end
    n_checks++; if (active    !== 1'b0)  begin n_fail++; $display("FAIL mid_rst_active got %b exp 0", active); end
    repeat (2) @(negedge clk_32f);
    reset = 1'b1;
    ticks = 0;
    send_bit(1'b1); if (byte_tick === 1'b1) ticks++;
    send_bit(1'b0); if (byte_tick === 1'b1) ticks++;
    send_bit(1'b1); if (byte_tick === 1'b1) ticks++;
    send_bit(1'b1); if (byte_tick === 1'b1) ticks++;
    send_bit(1'b1); if (byte_tick === 1'b1) ticks++;
    tail = '{8'h55, 8'h12};
    for (int k = 0; k < 2; k++) begin
      send_byte(tail[k]);
      ticks += extra_ticks;
      if (byte_tick === 1'b1) ticks++;
    end
    n_checks++; if (ticks != 0)          begin n_fail++; $display("FAIL post_rst_ticks got %0d exp 0", ticks); end
    n_checks++; if (active !== 1'b0)     begin n_fail++; $display("FAIL post_rst_active got %b exp 0", active); end
    send_byte(BC);
    n_checks++; if (byte_tick !== 1'b0)  begin n_fail++; $display("FAIL post_rst_hunt_tick got %b exp 0", byte_tick); end
    send_byte(BC);
    n_checks++; if (byte_tick !== 1'b1)  begin n_fail++; $display("FAIL post_rst_align_tick got %b exp 1", byte_tick); end
    n_checks++; if (data_out  !== BC)    begin n_fail++; $display("FAIL post_rst_align_data got %h exp bc", data_out); end
    n_checks++; if (active    !== 1'b0)  begin n_fail++; $display("FAIL post_rst_align_active got %b exp 0", active); end
  endtask

  // T6: back-to-back mix of payload and idle bytes after completing acquisition.
  task automatic test_back_to_back();
    logic [7:0] vec [20];
    logic [7:0] prev_data;
    logic       prev_valid;
    logic       exp_valid;
    vec = '{8'h01, BC,    8'h7E, 8'hFE, BC,    BC,    8'h3C, 8'hBD, 8'h00, 8'hC3,
            8'h5A, BC,    8'hA5, 8'h80, 8'h0F, 8'hF0, BC,    8'h42, 8'hBB, 8'h24};
    // T5 left two aligned commas; two more complete acquisition.
    send_byte(BC);
    send_byte(BC);
    n_checks++; if (active !== 1'b1) begin n_fail++; $display("FAIL b2b_active got %b exp 1", active); end
    prev_data  = BC;
    prev_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      exp_valid = (vec[k] != BC);
      send_byte(vec[k]);
      n_checks++; if (mid_data !== prev_data)   begin n_fail++; $display("FAIL b2b_hold_data byte %0d got %h exp %h", k, mid_data, prev_data); end
      n_checks++; if (mid_valid !== prev_valid) begin n_fail++; $display("FAIL b2b_hold_valid byte %0d got %b exp %b", k, mid_valid, prev_valid); end
      n_checks++; if (byte_tick !== 1'b1)       begin n_fail++; $display("FAIL b2b_tick byte %0d got %b exp 1", k, byte_tick); end
      n_checks++; if (extra_ticks != 0)         begin n_fail++; $display("FAIL b2b_extra_ticks byte %0d got %0d exp 0", k, extra_ticks); end
      n_checks++; if (data_out !== vec[k])      begin n_fail++; $display("FAIL b2b_data byte %0d got %h exp %h", k, data_out, vec[k]); end
      n_checks++; if (valid_out !== exp_valid)  begin n_fail++; $display("FAIL b2b_valid byte %0d got %b exp %b", k, valid_out, exp_valid); end
      prev_data  = vec[k];
      prev_valid = exp_valid;
    end
    n_checks++; if (active !== 1'b1) begin n_fail++; $display("FAIL b2b_active_end got %b exp 1", active); end
  endtask

  initial begin
    test_reset();
    test_acquisition();
    test_payload();
    test_failed_align();
    test_reset_mid_active();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_serie_paralelo_rx
